rev_apb_arbiter: RTL and testbench
==================================

Name: rev_apb_arbiter

Overview:
- Round-robin APB master arbiter that shares one APB slave port (e.g. the GPIO register block) among NREQ on-chip requesters.
- Each requester issues single read/write transfers over a valid/ready request channel and receives a one-cycle response pulse.
- The block sequences each granted transfer through APB SETUP and ACCESS phases, honours wait states, and aborts hung transfers with a timeout error.

Parameters:
- NREQ, 2: number of requesters, ≥2.
- PADDR_SIZE, 4: APB address width.
- DATA_W, 32: APB data width; a multiple of 8.
- TIMEOUT, 16: maximum ACCESS cycles allowed before abort; 0 disables the timeout.

Ports:
- pclk  in  1  single clock for all logic.
- prst  in  1  reset; asynchronous, active-high.
- req_valid  in  NREQ  per-requester transfer request; must be held until req_ready.
- req_write  in  NREQ  1=write, 0=read.
- req_addr  in  NREQ*PADDR_SIZE  flattened addresses; requester i occupies slice i.
- req_wdata  in  NREQ*DATA_W  flattened write data.
- req_strb  in  NREQ*DATA_W/8  flattened byte strobes.
- req_ready  out  NREQ  one-hot accept pulse, one cycle.
- rsp_valid  out  NREQ  one-hot completion pulse, one cycle.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid.
- busy  out  1  high whenever state≠IDLE.
- psel, penable, pwrite  out  1 each  APB controls.
- paddr  out  PADDR_SIZE  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB byte strobes.
- pready, pslverr  in  1 each  APB slave response.
- prdata  in  DATA_W  APB read data.

Behaviour:
- Reset (async, prst=1): all outputs 0; state=IDLE; last_grant=NREQ-1, so requester 0 has top priority first; timeout counter=0. Any in-flight transfer is dropped with no rsp_valid.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, at least one req_valid:
  - Grant g = first set bit scanning from last_grant+1 upward, wrapping modulo NREQ.
  - Register g, write, addr, wdata and strb (pwdata/pstrb forced to 0 on reads).
  - Pulse req_ready[g] in this cycle; next state SETUP.
- SETUP: psel=1, penable=0, APB outputs stable; next state ACCESS unconditionally.
- ACCESS: psel=1, penable=1.
  - pready=1 completes the transfer: rsp_valid[g]=1 next cycle; rsp_rdata=prdata for reads, 0 for writes; rsp_err=pslverr.
  - On completion: psel/penable=0, last_grant=g, return to IDLE.
- Timeout: the counter increments each ACCESS cycle with pready=0.
  - Reaching TIMEOUT (TIMEOUT>0) aborts: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, psel/penable=0, last_grant=g, IDLE.
  - The counter clears on leaving ACCESS and saturates; it never wraps.
- Latency: req_valid sampled in IDLE → req_ready same cycle → SETUP → ACCESS → rsp_valid one cycle after pready=1.
  - Zero wait states gives 3 cycles per transfer, so minimum spacing is 3 cycles.
  - A new arbitration occurs in the IDLE cycle that coincides with rsp_valid.
- paddr/pwrite/pwdata/pstrb hold their last value when psel=0.
- rsp_valid and req_ready are never set for more than one requester in the same cycle.
- A requester that drops req_valid before req_ready is a protocol violation; the bench asserts it.

Decomposition:
- Package rev_apb_pkg holds:
  - apb_state_e enum: IDLE, SETUP, ACCESS.
  - Localparams for the default PADDR_SIZE/DATA_W.
  - The timeout counter width function $clog2(TIMEOUT+1).
- Sub-module rev_rr_arbiter(NREQ) holds the round-robin pointer and the combinational next-grant logic.
  - Inputs: request vector, update enable, granted index.
  - Outputs: one-hot grant and encoded index.

Test Plan:
- Write, zero wait:
  - Stimulus: req0 write addr 0x1, wdata 0x0000_00FF, strb 0xF; pready=1.
  - Response: req_ready[0] at cycle T; psel=1/penable=0 at T+1; penable=1 at T+2 with paddr=0x1, pwdata=0xFF; rsp_valid[0]=1, rsp_err=0 at T+3.
- Read, wait states:
  - Stimulus: req1 read addr 0x3; pready=0 for 2 ACCESS cycles, then 1 with prdata=0xA5A5_5A5A.
  - Response: rsp_valid[1] with rsp_rdata=0xA5A5_5A5A at T+5; pstrb=0.
- Contention:
  - Stimulus: req0 and req1 held continuously.
  - Response: grant order 0,1,0,1 from reset; transfers spaced 3 cycles; no overlapping req_ready.
- Slave error:
  - Stimulus: pslverr=1 with pready=1.
  - Response: rsp_err=1 with rsp_valid; next transfer proceeds normally.
- Timeout:
  - Stimulus: TIMEOUT=8, pready stuck 0.
  - Response: after 8 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0, psel=0; busy falls.
- Reset mid-transfer:
  - Stimulus: assert prst during ACCESS.
  - Response: psel/penable/busy go 0 without a clock edge; no rsp_valid; after release, req0 and req1 both valid → req0 granted first.

Source files
------------

// File: rtl/rev_apb_pkg.sv
// rev_apb_pkg: shared state encoding, default widths and timeout counter sizing
package rev_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int DEF_PADDR_SIZE = 4;
  localparam int DEF_DATA_W = 32;
  function automatic int tmo_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/rev_rr_arbiter.sv
// rev_rr_arbiter: round-robin pointer with next-grant search starting after the last winner
module rev_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            pclk,
  input  logic            prst,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  input  logic [IW-1:0]   upd_idx,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] last, j;
  logic found;
  always_ff @(posedge pclk or posedge prst)
    if (prst) last <= IW'(NREQ - 1);
    else if (upd) last <= upd_idx;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = IW'((int'(last) + i) % NREQ);
      if (!found && req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    grant = '0;
    grant[idx] = found;
  end
endmodule

// File: rtl/rev_apb_arbiter.sv
// rev_apb_arbiter: round-robin sharing of one APB slave among NREQ requesters with timeout abort
module rev_apb_arbiter
  import rev_apb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int PADDR_SIZE = DEF_PADDR_SIZE,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*PADDR_SIZE-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*DATA_W/8-1:0] req_strb,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [PADDR_SIZE-1:0]    paddr,
  output logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W/8-1:0]      pstrb,
  input  logic                     pready,
  input  logic                     pslverr,
  input  logic [DATA_W-1:0]        prdata
);
  localparam int IW = $clog2(NREQ);
  localparam int SW = DATA_W / 8;
  localparam int TW = tmo_w(TIMEOUT);
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  apb_state_e state, state_n;
  logic [NREQ-1:0] grant, g_oh;
  logic [IW-1:0] idx, gidx;
  logic [TW-1:0] cnt;
  logic tmo_hit, fin, take;
  logic [PADDR_SIZE-1:0] addr_a [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];
  logic [SW-1:0] strb_a [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*PADDR_SIZE +: PADDR_SIZE];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    assign strb_a[i] = req_strb[i*SW +: SW];
  end
  assign tmo_hit = (TIMEOUT > 0) && (cnt == TLIM);
  assign fin = (state == ACCESS) && (pready || tmo_hit);
  assign take = (state == IDLE) && |req_valid;
  rev_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .pclk(pclk),
    .prst(prst),
    .req(req_valid),
    .upd(fin),
    .upd_idx(gidx),
    .grant(grant),
    .idx(idx)
  );
  always_ff @(posedge pclk or posedge prst)
    if (prst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE) ? (take ? SETUP : IDLE) :
              (state == SETUP) ? ACCESS :
              (fin ? IDLE : ACCESS);
  end
  always_comb begin
    psel = state != IDLE;
    penable = state == ACCESS;
    busy = state != IDLE;
    req_ready = (take && !prst) ? grant : '0;
  end
  always_ff @(posedge pclk or posedge prst)
    if (prst) begin
      gidx <= '0;
      g_oh <= '0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      pstrb <= '0;
      cnt <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (take) begin
        gidx <= idx;
        g_oh <= grant;
        pwrite <= req_write[idx];
        paddr <= addr_a[idx];
        pwdata <= req_write[idx] ? wdata_a[idx] : '0;
        pstrb <= req_write[idx] ? strb_a[idx] : '0;
      end
      cnt <= (state != ACCESS || fin) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
      rsp_valid <= fin ? g_oh : '0;
      rsp_rdata <= (fin && pready && !pwrite) ? prdata : '0;
      rsp_err <= fin && (!pready || pslverr);
    end
endmodule

// File: tb/tb_rev_apb_arbiter.sv
// tb_rev_apb_arbiter: directed checks of grant order, APB phasing, wait states, errors, timeout and reset
module tb_rev_apb_arbiter;
  logic pclk = 1'b0;
  logic prst = 1'b1;
  logic [1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [7:0] req_addr, req_strb;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, pwdata, prdata;
  logic rsp_err, busy, psel, penable, pwrite, pready, pslverr;
  logic [3:0] paddr, pstrb;
  logic [1:0] pv = 2'b00;
  logic [1:0] pr = 2'b00;
  int tests = 0;
  int fails = 0;
  always #5 pclk = ~pclk;
  rev_apb_arbiter #(.NREQ(2), .PADDR_SIZE(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge pclk) begin
    #3;
    if (!prst)
      for (int i = 0; i < 2; i++)
        assert (!(pv[i] && !pr[i] && !req_valid[i])) else begin
          fails++;
          $error("FAIL proto_drop req%0d: observed valid 0 expected 1", i);
        end
    pv <= req_valid;
    pr <= req_ready;
  end
  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (2) @(negedge pclk);
    req_valid = 2'b11;
    #1;
    chk("rst_psel", {31'd0, psel}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp", {30'd0, rsp_valid}, 0);
    chk("rst_ready", {30'd0, req_ready}, 0);
    req_valid = 2'b00;
    @(negedge pclk); prst = 1'b0;
    // write, zero wait states
    @(negedge pclk);
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h01;
    req_wdata = {32'h0, 32'h0000_00FF}; req_strb = 8'h0F; pready = 1'b1;
    #1;
    chk("w_ready", {30'd0, req_ready}, 32'h1);
    chk("w_busy_idle", {31'd0, busy}, 0);
    @(negedge pclk); req_valid = 2'b00; #1;
    chk("w_setup", {30'd0, psel, penable}, 32'h2);
    chk("w_paddr", {28'd0, paddr}, 32'h1);
    chk("w_pwdata", pwdata, 32'hFF);
    chk("w_pwrite", {31'd0, pwrite}, 1);
    chk("w_pstrb", {28'd0, pstrb}, 32'hF);
    @(negedge pclk); #1;
    chk("w_access", {30'd0, psel, penable}, 32'h3);
    chk("w_no_rsp", {30'd0, rsp_valid}, 0);
    @(negedge pclk); #1;
    chk("w_rsp", {30'd0, rsp_valid}, 32'h1);
    chk("w_err", {31'd0, rsp_err}, 0);
    chk("w_rdata", rsp_rdata, 0);
    chk("w_idle_psel", {31'd0, psel}, 0);
    chk("w_idle_busy", {31'd0, busy}, 0);
    chk("w_hold_addr", {28'd0, paddr}, 32'h1);
    // read with two wait states
    @(negedge pclk);
    req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h30;
    req_wdata = {32'h1234_5678, 32'h0}; req_strb = 8'hF0; pready = 1'b0; prdata = 32'hDEAD_BEEF;
    #1;
    chk("r_ready", {30'd0, req_ready}, 32'h2);
    @(negedge pclk); req_valid = 2'b00; #1;
    chk("r_pstrb", {28'd0, pstrb}, 0);
    chk("r_pwdata", pwdata, 0);
    chk("r_paddr", {28'd0, paddr}, 32'h3);
    chk("r_pwrite", {31'd0, pwrite}, 0);
    @(negedge pclk); #1;
    chk("r_wait1", {30'd0, psel, penable}, 32'h3);
    chk("r_wait1_rsp", {30'd0, rsp_valid}, 0);
    @(negedge pclk); #1;
    chk("r_wait2_rsp", {30'd0, rsp_valid}, 0);
    @(negedge pclk); pready = 1'b1; prdata = 32'hA5A5_5A5A;
    @(negedge pclk); #1;
    chk("r_rsp", {30'd0, rsp_valid}, 32'h2);
    chk("r_rdata", rsp_rdata, 32'hA5A5_5A5A);
    chk("r_err", {31'd0, rsp_err}, 0);
    // slave error, then a normal transfer
    @(negedge pclk);
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h02; pslverr = 1'b1;
    #1;
    chk("e_ready", {30'd0, req_ready}, 32'h1);
    @(negedge pclk); req_valid = 2'b00;
    @(negedge pclk);
    @(negedge pclk); #1;
    chk("e_rsp", {30'd0, rsp_valid}, 32'h1);
    chk("e_err", {31'd0, rsp_err}, 1);
    @(negedge pclk);
    pslverr = 1'b0; req_valid = 2'b10; req_write = 2'b10; req_addr = 8'h50;
    #1;
    chk("n_ready", {30'd0, req_ready}, 32'h2);
    @(negedge pclk); req_valid = 2'b00;
    @(negedge pclk);
    @(negedge pclk); #1;
    chk("n_rsp", {30'd0, rsp_valid}, 32'h2);
    chk("n_err", {31'd0, rsp_err}, 0);
    // timeout with pready stuck low
    @(negedge pclk);
    req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h70; pready = 1'b0; prdata = 32'hFFFF_FFFF;
    #1;
    chk("t_ready", {30'd0, req_ready}, 32'h2);
    @(negedge pclk); req_valid = 2'b00;
    repeat (7) @(negedge pclk);
    @(negedge pclk); #1;
    chk("t_acc8", {30'd0, psel, penable}, 32'h3);
    chk("t_acc8_rsp", {30'd0, rsp_valid}, 0);
    @(negedge pclk); #1;
    chk("t_rsp", {30'd0, rsp_valid}, 32'h2);
    chk("t_err", {31'd0, rsp_err}, 1);
    chk("t_rdata", rsp_rdata, 0);
    chk("t_psel", {31'd0, psel}, 0);
    chk("t_busy", {31'd0, busy}, 0);
    // reset during ACCESS
    @(negedge pclk);
    req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h00;
    #1;
    chk("m_ready", {30'd0, req_ready}, 32'h1);
    @(negedge pclk); req_valid = 2'b00;
    @(negedge pclk); #1;
    chk("m_access", {30'd0, psel, penable}, 32'h3);
    prst = 1'b1; req_valid = 2'b11;
    #1;
    chk("m_async", {29'd0, psel, penable, busy}, 0);
    chk("m_ready_rst", {30'd0, req_ready}, 0);
    @(negedge pclk); #1;
    chk("m_no_rsp", {30'd0, rsp_valid}, 0);
    // contention from reset: 0,1,0,1 every 3 cycles
    @(negedge pclk); prst = 1'b0; pready = 1'b1; #1;
    chk("c_ready0", {30'd0, req_ready}, 32'h1);
    @(negedge pclk); #1;
    chk("c_gap", {30'd0, req_ready}, 0);
    @(negedge pclk);
    @(negedge pclk); #1;
    chk("c_ready1", {30'd0, req_ready}, 32'h2);
    chk("c_rsp0", {30'd0, rsp_valid}, 32'h1);
    repeat (2) @(negedge pclk);
    @(negedge pclk); #1;
    chk("c_ready2", {30'd0, req_ready}, 32'h1);
    chk("c_rsp1", {30'd0, rsp_valid}, 32'h2);
    repeat (2) @(negedge pclk);
    @(negedge pclk); #1;
    chk("c_ready3", {30'd0, req_ready}, 32'h2);
    chk("c_rsp2", {30'd0, rsp_valid}, 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
